// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter; one transaction in flight, 3-cycle best-case latency.
// Optional `MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties; default is fixed priority LSU > IFU.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                own_ls_q, own_ls_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                grant_ls;
    logic                idle;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_ls_q: 1 when the LSU was the most recently accepted master.
    logic last_ls_q, last_ls_d;

    always_comb begin
        if (if_req_valid && ls_req_valid) begin
            grant_ls = !last_ls_q;
        end else begin
            grant_ls = ls_req_valid;
        end
        last_ls_d = last_ls_q;
        if (if_req_ready || ls_req_ready) begin
            last_ls_d = ls_req_ready;
        end
    end
`else
    assign grant_ls = ls_req_valid;
`endif

    // Readies are masked during reset so no master sees a phantom accept.
    assign idle         = rst_n && (state_q == IDLE);
    assign ls_req_ready = idle && grant_ls;
    assign if_req_ready = idle && if_req_valid && !grant_ls;

    always_comb begin
        state_d    = state_q;
        own_ls_d   = own_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (ls_req_ready) begin
                    own_ls_d = 1'b1;
                    we_d     = ls_we;
                    addr_d   = ls_addr;
                    wdata_d  = ls_wdata;
                    wstrb_d  = ls_we ? ls_wstrb : '0;
                    state_d  = REQ;
                end else if (if_req_ready) begin
                    own_ls_d = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (own_ls_q) begin
                        ls_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            own_ls_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            own_ls_q   <= own_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls_q  <= last_ls_d;
`endif
        end
    end

    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req && we_q;
    assign mem_addr     = mem_req ? addr_q  : '0;
    assign mem_wdata    = mem_req ? wdata_q : '0;
    assign mem_wstrb    = mem_req ? wstrb_q : '0;

    assign if_rsp_valid = (state_q == RESP) && !own_ls_q;
    assign ls_rsp_valid = (state_q == RESP) && own_ls_q;
    assign if_rsp_data  = if_rdata_q;
    assign ls_rsp_data  = ls_rdata_q;
endmodule
